// File: rtl/rgmii_recv_if.sv
// RGMII receive framer bus: demultiplexed RX nibbles/control in, MAC-side byte stream out.
// master = framer side, slave = PHY/consumer side.
interface rgmii_recv_if;
  logic [3:0] rx_h;
  logic [3:0] rx_l;
  logic       ctl_h;
  logic       ctl_l;
  logic [7:0] data;
  logic       rx_enable;
  logic       active;
  logic       frame_end;
  logic       frame_bad;

  modport master (
    input  rx_h, rx_l, ctl_h, ctl_l,
    output data, rx_enable, active, frame_end, frame_bad
  );

  modport slave (
    output rx_h, rx_l, ctl_h, ctl_l,
    input  data, rx_enable, active, frame_end, frame_bad
  );
endinterface

// File: rtl/rgmii_recv.sv
// RGMII receive framer: strips preamble/SFD, streams payload bytes, flags bad frames at end.
// Optional CRC-32 frame check enabled by defining RGMII_RECV_CRC_EN.
module rgmii_recv #(
  parameter int unsigned MIN_FRAME = 64
) (
  input  logic          clock,
  input  logic          reset,
  rgmii_recv_if.master  bus
);

  localparam int unsigned     LenW   = $clog2(MIN_FRAME) + 1;
  localparam logic [LenW-1:0] LenMax = LenW'(MIN_FRAME);

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

  state_e          state_q;
  logic [2:0]      pre_cnt_q;
  logic [LenW-1:0] len_cnt_q;
  logic            err_q;
  logic [7:0]      data_q;
  logic            rx_enable_q;
  logic            active_q;
  logic            frame_end_q;
  logic            frame_bad_q;

  logic [7:0] rx_byte;
  logic       dv;
  logic       er;
  logic       crc_fail;

  assign rx_byte = {bus.rx_l, bus.rx_h};
  assign dv      = bus.ctl_h;
  assign er      = bus.ctl_h ^ bus.ctl_l;

`ifdef RGMII_RECV_CRC_EN
  logic [31:0] crc_q;

  // Reflected CRC-32, one byte per call, no final inversion.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Running over the FCS too leaves the fixed residue on a good frame.
  assign crc_fail = (crc_q != 32'hDEBB20E3);
`else
  assign crc_fail = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StDrop;
      pre_cnt_q   <= '0;
      len_cnt_q   <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
      rx_enable_q <= 1'b0;
      active_q    <= 1'b0;
      frame_end_q <= 1'b0;
      frame_bad_q <= 1'b0;
`ifdef RGMII_RECV_CRC_EN
      crc_q       <= 32'hFFFFFFFF;
`endif
    end else begin
      rx_enable_q <= 1'b0;
      frame_end_q <= 1'b0;
      frame_bad_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (dv) begin
            if (rx_byte == 8'h55) begin
              state_q   <= StPreamble;
              pre_cnt_q <= 3'd1;
              active_q  <= 1'b1;
            end else begin
              state_q <= StDrop;
            end
          end
        end
        StPreamble: begin
          if (!dv) begin
            state_q  <= StIdle;
            active_q <= 1'b0;
          end else if (er) begin
            state_q  <= StDrop;
            active_q <= 1'b0;
          end else if (rx_byte == 8'h55) begin
            if (pre_cnt_q != 3'd7) pre_cnt_q <= pre_cnt_q + 3'd1;
          end else if (rx_byte == 8'hD5) begin
            state_q   <= StData;
            len_cnt_q <= '0;
            err_q     <= 1'b0;
`ifdef RGMII_RECV_CRC_EN
            crc_q     <= 32'hFFFFFFFF;
`endif
          end else begin
            state_q  <= StDrop;
            active_q <= 1'b0;
          end
        end
        StData: begin
          if (dv) begin
            data_q      <= rx_byte;
            rx_enable_q <= 1'b1;
            if (len_cnt_q != LenMax) len_cnt_q <= len_cnt_q + 1'b1;
            err_q       <= err_q | er;
`ifdef RGMII_RECV_CRC_EN
            crc_q       <= crc_step(crc_q, rx_byte);
`endif
          end else begin
            frame_end_q <= 1'b1;
            frame_bad_q <= err_q | (len_cnt_q < LenMax) | crc_fail;
            state_q     <= StIdle;
            active_q    <= 1'b0;
          end
        end
        StDrop: begin
          if (!dv) state_q <= StIdle;
        end
        default: state_q <= StDrop;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.rx_enable = rx_enable_q;
  assign bus.active    = active_q;
  assign bus.frame_end = frame_end_q;
  assign bus.frame_bad = frame_bad_q;

endmodule

// File: doc/rgmii_recv.md
# rgmii_recv

Receive-side RGMII framer, the counterpart of the transmit serializer on the same PHY. It takes the RX nibbles and RX_CTL already demultiplexed from the DDR pins by the top-level `ddio_in` instance, all in the PHY RX clock domain. It strips preamble and SFD, and delivers payload bytes (FCS included) to the MAC-side parser as a byte stream with a valid strobe. At frame end it emits a one-cycle end strobe with a bad-frame flag.

## Interface
- `MIN_FRAME`, default 64: minimum payload byte count, counted after the SFD and including the FCS. Shorter frames are flagged bad.
- `clock` input 1: PHY RX clock (125/25/2.5 MHz); the single clock of the block.
- `reset` input 1: synchronous, active-high.
- `rx_h` input 4: nibble captured on the rising edge; this is the low nibble of the byte.
- `rx_l` input 4: nibble captured on the falling edge; this is the high nibble of the byte.
- `ctl_h` input 1: RX_CTL on the rising edge, i.e. RX_DV.
- `ctl_l` input 1: RX_CTL on the falling edge, i.e. RX_DV xor RX_ER.
- `data` output 8: payload byte, equal to {rx_l, rx_h} registered.
- `rx_enable` output 1: `data` valid this cycle.
- `active` output 1: high while in ST_PREAMBLE or ST_DATA.
- `frame_end` output 1: one-cycle strobe after the last payload byte.
- `frame_bad` output 1: qualifies `frame_end`; 0 whenever `frame_end` is 0.

## Operation
- Per-cycle decode: byte = {rx_l, rx_h}, dv = ctl_h, er = ctl_h ^ ctl_l.
- ST_IDLE:
  - dv & byte==8'h55 → ST_PREAMBLE, pre_cnt=1.
  - dv & any other byte, including 8'hD5 → ST_DROP.
  - !dv → stay. This covers false carrier and carrier extend (dv=0, er=1), which are ignored.
- ST_PREAMBLE:
  - !dv → ST_IDLE.
  - byte==8'h55 → pre_cnt++, saturating at 7.
  - byte==8'hD5 → ST_DATA; clear len_cnt, err flag and CRC.
  - any other byte → ST_DROP.
  - A shortened preamble of at least one 8'h55 is accepted.
- ST_DATA:
  - dv → emit byte; len_cnt++, saturating at MIN_FRAME; err |= er.
  - !dv → pulse `frame_end` with frame_bad = err | (len_cnt < MIN_FRAME) | crc_fail; → ST_IDLE.
- ST_DROP: hold until !dv → ST_IDLE. No outputs are produced, including `frame_end`.
- SFD immediately followed by dv low: `frame_end`=1, `frame_bad`=1, no `rx_enable`.
- Any er during ST_PREAMBLE → ST_DROP.
- len_cnt width is clog2(MIN_FRAME)+1 bits and saturates, so frames of any length never wrap.

## Timing
- Reset values: data=0, rx_enable=0, active=0, frame_end=0, frame_bad=0.
- Reset puts the state machine in ST_DROP, not ST_IDLE, so a frame in progress at reset is discarded up to its next dv-low.
- All outputs are registered. Latency is 1 cycle: a byte at the inputs in cycle N appears on `data` / `rx_enable` in N+1.
- The SFD byte and the preamble bytes are never output. The first `rx_enable` is at N+1 for the byte in cycle N after the SFD cycle.
- The first dv-low cycle M after the payload gives `frame_end` in M+1. This is exactly one cycle after the last `rx_enable`; the two are never asserted together.
- Back-to-back frames with a 1-cycle dv-low gap: `frame_end` of frame A and the preamble of frame B are both handled, since ST_IDLE is entered in the same cycle as the `frame_end` decision.
- `active` rises the cycle after the first 8'h55 and falls together with the `frame_end` strobe.
- No backpressure: the consumer must accept one byte per clock.

## Configuration
- `RGMII_RECV_CRC_EN` defined:
  - Reflected CRC-32 (poly 32'hEDB88320, init 32'hFFFFFFFF) runs over every payload byte, FCS included.
  - crc_fail = (register != 32'hDEBB20E3) at end of frame.
- Not defined: no CRC logic; crc_fail=0; `frame_bad` reflects only er and runt length.

## Test plan
- 7×55, D5, 60 payload bytes 00..3B plus a valid 4-byte FCS, then dv low → 64 `rx_enable` cycles with data 00..3B then the FCS; `frame_end`=1, `frame_bad`=0, one cycle after the last byte.
- Same frame with payload byte 10 corrupted → `frame_bad`=1 with CRC_EN defined; `frame_bad`=0 without it.
- 1×55, D5, 20 bytes → 20 bytes output, `frame_end` with `frame_bad`=1 (runt).
- 7×55, A5, 50 bytes → no `rx_enable`, no `frame_end`, `active` low after the A5. The next valid frame is received normally.
- Valid 64-byte frame with er asserted (ctl_l=0) on byte 30 → all 64 bytes output, `frame_bad`=1.
- `reset` pulsed at payload byte 20, then dv kept high → outputs 0 from reset onward, rest of the frame ignored. A following frame after a 1-cycle gap is received correctly.
